// File: rtl/tft_bus_pkg.sv
// +----------------------------------------------------------------------+
// | tft_bus_pkg: shared FSM encoding and client indices for the TFT bus  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package tft_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int CLIENT_INIT   = 0;
  localparam int CLIENT_SCENE  = 1;
  localparam int CLIENT_PLAYER = 2;

endpackage

`default_nettype wire

// File: rtl/tft_rr_pick.sv
// +----------------------------------------------------------------------+
// | tft_rr_pick: combinational round-robin picker (first after last_idx) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tft_rr_pick #(
  parameter int NUM_CLIENTS = 3,
  parameter int ID_W        = 3
) (
  input  logic [NUM_CLIENTS-1:0] eligible,
  input  logic [ID_W-1:0]        last_idx,
  output logic                   valid,
  output logic [ID_W-1:0]        index
);

  // The scan visits last_idx itself last, so a lone requester can be re-served.
  always_comb begin
    logic [ID_W-1:0] cand;
    valid = 1'b0;
    index = '0;
    cand  = last_idx;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = (cand == ID_W'(NUM_CLIENTS - 1)) ? '0 : cand + ID_W'(1);
      if (!valid && |(eligible & (NUM_CLIENTS'(1) << cand))) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tft_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tft_bus_arbiter: shares one tft_spi between byte-stream clients      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tft_bus_arbiter
  import tft_bus_pkg::*;
#(
  parameter int NUM_CLIENTS   = 3,
  parameter int START_TIMEOUT = 15,
  parameter int ID_W          = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req,
  input  logic [NUM_CLIENTS-1:0]   client_busy,
  input  logic [8*NUM_CLIENTS-1:0] client_data,
  input  logic [NUM_CLIENTS-1:0]   client_dc,
  input  logic [NUM_CLIENTS-1:0]   client_transmit,
  input  logic                     spi_busy,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic [7:0]               spi_data,
  output logic                     spi_dc,
  output logic                     spi_transmit,
  output logic                     init_done,
  output logic [ID_W-1:0]          active_id,
  output logic                     busy
);

  localparam int                     CNT_W     = $clog2(START_TIMEOUT + 1);
  localparam logic [NUM_CLIENTS-1:0] INIT_MASK = NUM_CLIENTS'(1) << CLIENT_INIT;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ID_W-1:0]        r_last;

  logic [NUM_CLIENTS-1:0] w_eligible;
  logic                   w_pick_valid;
  logic [ID_W-1:0]        w_pick_idx;
  logic                   w_active_busy;

  // Before init completes only the initializer may win; afterwards it never can.
  assign w_eligible    = init_done ? (req & ~INIT_MASK) : (req & INIT_MASK);
  assign w_active_busy = |(client_busy & grant);
  assign busy          = (r_state != IDLE);

  tft_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .ID_W        (ID_W)
  ) u_pick (
    .eligible (w_eligible),
    .last_idx (r_last),
    .valid    (w_pick_valid),
    .index    (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      grant     <= '0;
      active_id <= '0;
      init_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            grant     <= NUM_CLIENTS'(1) << w_pick_idx;
            active_id <= w_pick_idx;
            r_last    <= w_pick_idx;
            r_cnt     <= '0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_active_busy) begin
            r_state <= RUN;
          end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
            // Client never started: revoke without crediting init completion.
            grant     <= '0;
            active_id <= '0;
            r_cnt     <= CNT_W'(START_TIMEOUT);
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!w_active_busy) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!spi_busy) begin
            if (active_id == ID_W'(CLIENT_INIT)) init_done <= 1'b1;
            grant     <= '0;
            active_id <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant[i]) begin
        spi_data     = client_data[8*i +: 8];
        spi_dc       = client_dc[i];
        spi_transmit = client_transmit[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tft_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_tft_bus_arbiter: directed self-checking bench for tft_bus_arbiter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tft_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  client_busy = '0;
  logic [23:0] client_data = '0;
  logic [2:0]  client_dc = '0;
  logic [2:0]  client_transmit = '0;
  logic        spi_busy = 1'b0;
  logic [2:0]  grant;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_transmit;
  logic        init_done;
  logic [2:0]  active_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  tft_bus_arbiter #(.NUM_CLIENTS(3), .START_TIMEOUT(15), .ID_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .client_busy     (client_busy),
    .client_data     (client_data),
    .client_dc       (client_dc),
    .client_transmit (client_transmit),
    .spi_busy        (spi_busy),
    .grant           (grant),
    .spi_data        (spi_data),
    .spi_dc          (spi_dc),
    .spi_transmit    (spi_transmit),
    .init_done       (init_done),
    .active_id       (active_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Waits (bounded) for any grant; cycles = negedges waited, -1 on expiry.
  task automatic wait_grant(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (grant !== 3'b000) begin
        cycles = k;
        break;
      end
    end
  endtask

  // Plays client c's job: busy for busy_cyc cycles, then waits for release.
  task automatic finish_job(input int c, input int busy_cyc, output int drop_cycles, output int held_bad);
    logic [2:0] exp_g;
    exp_g = 3'b001 << c;
    held_bad = 0;
    client_busy[c] = 1'b1;
    repeat (busy_cyc) begin
      @(negedge clk);
      if (grant !== exp_g) held_bad++;
    end
    client_busy[c] = 1'b0;
    drop_cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (grant === 3'b000) begin
        drop_cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    client_data = 24'hFFFFFF;
    client_dc = 3'b111;
    client_transmit = 3'b111;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_cmp++; if (active_id !== 3'd0) begin n_fail++; $display("FAIL reset_active_id: got %0d want 0", active_id); end
    n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (spi_data !== 8'h00) begin n_fail++; $display("FAIL reset_spi_data: got %h want 00", spi_data); end
    n_cmp++; if (spi_transmit !== 1'b0 || spi_dc !== 1'b0) begin n_fail++; $display("FAIL reset_spi_ctl: got tx=%b dc=%b want 0 0", spi_transmit, spi_dc); end
    client_data = '0;
    client_dc = '0;
    client_transmit = '0;
    rst = 1'b1;
  endtask

  task automatic test_post_reset_order();
    int cyc, drop, bad;
    req = 3'b111;
    wait_grant(cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL order_latency: got %0d want 1", cyc); end
    n_cmp++; if (grant !== 3'b001) begin n_fail++; $display("FAIL order_first_grant: got %b want 001", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL order_busy: got %b want 1", busy); end
    finish_job(0, 3, drop, bad);
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL order_init_exclusive: got %0d bad cycles want 0", bad); end
    n_cmp++; if (drop !== 2) begin n_fail++; $display("FAIL order_init_release: got %0d want 2", drop); end
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL order_init_done: got %b want 1", init_done); end
    wait_grant(cyc);
    n_cmp++; if (grant !== 3'b010 || active_id !== 3'd1) begin n_fail++; $display("FAIL order_second: got %b id %0d want 010 id 1", grant, active_id); end
    finish_job(1, 2, drop, bad);
    wait_grant(cyc);
    n_cmp++; if (grant !== 3'b100 || active_id !== 3'd2) begin n_fail++; $display("FAIL order_third: got %b id %0d want 100 id 2", grant, active_id); end
    finish_job(2, 2, drop, bad);
    req = 3'b110;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [5];
    int         exp_id [5];
    int cyc, drop, bad;
    exp_g = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
    exp_id = '{1, 2, 1, 2, 1};
    for (int i = 0; i < 5; i++) begin
      wait_grant(cyc);
      n_cmp++; if (grant !== exp_g[i] || active_id !== exp_id[i][2:0]) begin
        n_fail++; $display("FAIL rr_step%0d: got %b id %0d want %b id %0d", i, grant, active_id, exp_g[i], exp_id[i]);
      end
      finish_job(exp_id[i], 5, drop, bad);
      n_cmp++; if (bad !== 0 || drop !== 2) begin
        n_fail++; $display("FAIL rr_job%0d: got bad=%0d drop=%0d want 0 2", i, bad, drop);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_mux_isolation();
    int cyc, drop, bad;
    req = 3'b010;
    wait_grant(cyc);
    n_cmp++; if (grant !== 3'b010) begin n_fail++; $display("FAIL mux_grant: got %b want 010", grant); end
    client_data = {8'hA5, 8'h3C, 8'h77};
    client_dc = 3'b101;
    client_transmit = 3'b101;
    #1;
    n_cmp++; if (spi_transmit !== 1'b0) begin n_fail++; $display("FAIL mux_tx_isolated: got %b want 0", spi_transmit); end
    n_cmp++; if (spi_data !== 8'h3C) begin n_fail++; $display("FAIL mux_data: got %h want 3c", spi_data); end
    n_cmp++; if (spi_dc !== 1'b0) begin n_fail++; $display("FAIL mux_dc_isolated: got %b want 0", spi_dc); end
    client_transmit = 3'b111;
    client_dc = 3'b111;
    #1;
    n_cmp++; if (spi_transmit !== 1'b1 || spi_dc !== 1'b1) begin n_fail++; $display("FAIL mux_forward: got tx=%b dc=%b want 1 1", spi_transmit, spi_dc); end
    client_transmit = '0;
    client_dc = '0;
    finish_job(1, 2, drop, bad);
  endtask

  task automatic test_drain_hold();
    int cyc;
    wait_grant(cyc);
    n_cmp++; if (cyc !== 1 || grant !== 3'b010) begin n_fail++; $display("FAIL drain_regrant: got %b after %0d want 010 after 1", grant, cyc); end
    client_busy[1] = 1'b1;
    spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    client_busy[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 3'b010) begin n_fail++; $display("FAIL drain_hold%0d: got %b want 010", k, grant); end
    end
    spi_busy = 1'b0;
    req = 3'b000;
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_release: got %b busy %b want 000 0", grant, busy); end
  endtask

  task automatic test_start_timeout();
    int cyc, n;
    req = 3'b100;
    wait_grant(cyc);
    n_cmp++; if (grant !== 3'b100) begin n_fail++; $display("FAIL to_grant: got %b want 100", grant); end
    n = 0;
    while (grant === 3'b100 && n < 40) begin
      n++;
      @(negedge clk);
    end
    req = 3'b000;
    n_cmp++; if (n !== 15) begin n_fail++; $display("FAIL to_cycles: got %0d want 15", n); end
    n_cmp++; if (busy !== 1'b0 || active_id !== 3'd0) begin n_fail++; $display("FAIL to_idle: got busy %b id %0d want 0 0", busy, active_id); end
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL to_init_kept: got %b want 1", init_done); end
    @(negedge clk);
    n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL to_no_regrant: got %b want 000", grant); end
  endtask

  task automatic test_async_reset();
    int cyc, drop, bad;
    req = 3'b010;
    wait_grant(cyc);
    client_busy[1] = 1'b1;
    client_transmit = 3'b010;
    repeat (2) @(negedge clk);
    n_cmp++; if (grant !== 3'b010 || spi_transmit !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got %b tx %b want 010 1", grant, spi_transmit); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL ar_grant: got %b want 000", grant); end
    n_cmp++; if (spi_transmit !== 1'b0) begin n_fail++; $display("FAIL ar_tx: got %b want 0", spi_transmit); end
    n_cmp++; if (init_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_state: got init %b busy %b want 0 0", init_done, busy); end
    client_busy = '0;
    client_transmit = '0;
    req = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    wait_grant(cyc);
    n_cmp++; if (grant !== 3'b001 || active_id !== 3'd0) begin n_fail++; $display("FAIL ar_first_grant: got %b id %0d want 001 id 0", grant, active_id); end
    finish_job(0, 2, drop, bad);
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL ar_init_done: got %b want 1", init_done); end
    req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_post_reset_order();
    test_round_robin();
    test_mux_isolation();
    test_drain_hold();
    test_start_timeout();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tft_bus_arbiter.md
Name: tft_bus_arbiter

Overview:
- Owns the single tft_spi transmitter and shares it between byte-stream clients (tft_init, scene_exhibitor, player, ...).
- Replaces the ad-hoc enable chain in the Maze top level.
- Client 0 is the initializer. It has exclusive access after reset until it completes once. Clients 1..N-1 are then served round-robin, one job at a time.
- Each grant is the client's enable. The winning client's data/dc/transmit are routed to tft_spi.

Parameters:
- NUM_CLIENTS, 3, number of clients (2..8); index 0 is the initializer.
- START_TIMEOUT, 15, cycles to wait for a granted client to raise busy before revoking the grant.
- ID_W, 3, width of active_id; must be at least clog2(NUM_CLIENTS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- req  in  NUM_CLIENTS  per-client access request, level.
- client_busy  in  NUM_CLIENTS  per-client busy (the client's existing busy output).
- client_data  in  8*NUM_CLIENTS  packed bytes; client i uses bits [8i+7:8i].
- client_dc  in  NUM_CLIENTS  per-client dc.
- client_transmit  in  NUM_CLIENTS  per-client transmit strobe.
- spi_busy  in  1  tft_spi busy.
- grant  out  NUM_CLIENTS  one-hot or zero; drives client enable.
- spi_data  out  8  to tft_spi data.
- spi_dc  out  1  to tft_spi dc.
- spi_transmit  out  1  to tft_spi transmit.
- init_done  out  1  high once client 0 has completed; sticky until reset.
- active_id  out  ID_W  index of the granted client; 0 when idle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=0): every output is 0; state=IDLE; round-robin pointer=0 (last served = client 0).
- States: IDLE, START, RUN, DRAIN.
- IDLE:
  - If init_done=0: only req[0] is eligible.
  - If init_done=1: only req[1..N-1] are eligible. req[0] is ignored permanently.
  - Winner = first eligible index strictly after the last served, wrapping.
  - On a winner: the next edge registers grant, active_id and the pointer, clears the timeout counter and enters START.
  - Grant is therefore visible 1 cycle after req is sampled.
- START:
  - If client_busy[active]=1, go to RUN.
  - Otherwise the counter increments. When it reaches START_TIMEOUT, grant drops and the block goes to IDLE. init_done is not set on timeout.
- RUN: when client_busy[active]=0, go to DRAIN. grant stays high.
- DRAIN:
  - When spi_busy=0: grant drops, and the block returns to IDLE. If active=0, init_done is set.
  - A new grant is therefore issued no earlier than 1 cycle after the release cycle.
- Mux (combinational from the registered grant):
  - spi_data/spi_dc/spi_transmit = the granted client's signals.
  - When grant=0, all three are 0. Ungranted clients' transmit is never forwarded.
- Request withdrawal: dropping req while granted is ignored. The grant is held until the job completes or times out.
- A client with client_busy=1 that is not granted has no effect.
- Simultaneous requests (eligible set 1 and 2, last served 1): grant 2. On the next arbitration with both still requesting: grant 1.
- A single requester may be re-granted back to back.
- Reset mid-job: grant and spi_transmit drop immediately (asynchronously). After release, arbitration restarts with init only. tft_spi is reset by the same reset.
- Timeout counter width: clog2(START_TIMEOUT+1). It saturates and never wraps.

Decomposition:
- Shared package tft_bus_pkg: state encoding (IDLE=0, START=1, RUN=2, DRAIN=3) and the client index constants CLIENT_INIT=0, CLIENT_SCENE=1, CLIENT_PLAYER=2.
- One sub-module: tft_rr_pick. It is the combinational round-robin picker with inputs eligible mask and last index, and outputs valid and index.
- The mux and FSM stay in tft_bus_arbiter.

Test Plan:
- Post-reset ordering:
  - Stimulus: req=3'b111 after reset.
  - Required: grant=3'b001 first. No other grant until init_done=1. Then grant=3'b010, then 3'b100.
- Round-robin:
  - Stimulus: init done, last served 1; hold req[1] and req[2] high with 5-cycle busy pulses.
  - Required: grants alternate 100, 010, 100, 010. active_id alternates 2, 1.
- Drain hold:
  - Stimulus: client 1 drops busy while spi_busy stays high for 4 more cycles.
  - Required: grant[1] stays high those 4 cycles. Grant falls on the first cycle with spi_busy=0.
- Start timeout:
  - Stimulus: client 2 granted but client_busy never rises, START_TIMEOUT=15.
  - Required: grant drops after exactly 15 START cycles, then state IDLE and busy=0.
- Mux isolation:
  - Stimulus: client 2 pulses transmit with data 8'hA5 while client 1 is granted.
  - Required: spi_transmit stays 0, spi_data equals client 1's byte.
- Async reset mid-RUN:
  - Stimulus: rst low between clock edges.
  - Required: grant, spi_transmit and init_done are 0 immediately. After release, the first grant goes to client 0 only.
